// File: rtl/sha256_pkg.sv
// Shared constants, FSM encoding and small helpers for the SHA-256 block sequencer.
package sha256_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned BLOCK_W     = WORD_W * BLOCK_WORDS;
  localparam int unsigned STATE_W     = 256;

  // Initial hash value, H0 (6a09e667) in the low word.
  localparam logic [STATE_W-1:0] SHA256_H0 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad,
    StRun,
    StFinish,
    StCapture
  } seq_state_e;

  // Bit offset of word idx inside a 512-bit block.
  function automatic logic [8:0] word_lsb(input logic [3:0] idx);
    return {idx, 5'b0};
  endfunction

  function automatic logic [2:0] sat_bytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Masks a final message word to its valid bytes and appends the 0x80 pad marker.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  nbytes,
  output logic [31:0] padded,
  output logic        overflow
);

  logic [2:0] nb;

  assign nb       = sat_bytes(nbytes);
  assign overflow = (nb == 3'd4);

  // A full word leaves no room for the marker; it lands in the next word instead.
  always_comb begin
    padded = word;
    unique case (nb)
      3'd0:    padded = 32'h8000_0000;
      3'd1:    padded = {word[31:24], 24'h80_0000};
      3'd2:    padded = {word[31:16], 16'h8000};
      3'd3:    padded = {word[31:8], 8'h80};
      default: padded = word;
    endcase
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Streams message words into padded 512-bit blocks, drives an iterative SHA-256 transform
// and chains its output across blocks into one digest per message.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [2:0]           in_bytes,
  output logic                 in_ready,
  output logic                 feedback,
  output logic [5:0]           cnt,
  output logic [BLOCK_W-1:0]   rx_input,
  output logic [STATE_W-1:0]   rx_state,
  input  logic [STATE_W-1:0]   tx_hash,
  output logic [STATE_W-1:0]   digest,
  output logic                 digest_valid
);

  seq_state_e state_q, state_d;

  logic [BLOCK_W-1:0] block_q, block_d;
  logic [STATE_W-1:0] chain_q, chain_d, digest_q, digest_d;
  logic               digest_valid_q, digest_valid_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [3:0]         widx_q, widx_d, last_idx_q, last_idx_d, wr_idx;
  logic [2:0]         last_bytes_q, last_bytes_d;
  logic [LEN_W-1:0]   len_q, len_d, word_bits;
  logic               final_q, final_d, pend_q, pend_d, need80_q, need80_d;
  logic [63:0]        len64;
  logic [31:0]        pad_out;
  logic               pad_ovf, pad_fits, accept;

  sha256_pad_word u_pad_word (
    .word     (block_q[word_lsb(last_idx_q) +: WORD_W]),
    .nbytes   (last_bytes_q),
    .padded   (pad_out),
    .overflow (pad_ovf)
  );

  assign accept    = in_valid & in_ready;
  assign wr_idx    = (state_q == StIdle) ? 4'd0 : widx_q;
  assign word_bits = in_last ? LEN_W'({sat_bytes(in_bytes), 3'b000}) : LEN_W'(32);
  assign len64     = 64'(len_q);
  // Length fits when the marker word leaves W14/W15 free.
  assign pad_fits  = ({1'b0, last_idx_q} + {4'd0, pad_ovf}) <= 5'd13;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = in_last ? StPad : StLoad;
      StLoad:    if (accept) state_d = in_last ? StPad : ((widx_q == 4'd15) ? StRun : StLoad);
      StPad:     state_d = StRun;
      StRun:     if (cnt_q == 6'd63) state_d = StFinish;
      StFinish:  state_d = StCapture;
      StCapture: state_d = final_q ? StIdle : (pend_q ? StPad : StLoad);
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = reset_n && ((state_q == StIdle) || (state_q == StLoad));
    feedback = (state_q == StRun) && (cnt_q != 6'd0);
    cnt      = (state_q == StRun) ? cnt_q : 6'd0;
  end

  always_comb begin
    block_d        = block_q;
    chain_d        = chain_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    cnt_d          = cnt_q;
    widx_d         = widx_q;
    last_idx_d     = last_idx_q;
    last_bytes_d   = last_bytes_q;
    len_d          = len_q;
    final_d        = final_q;
    pend_d         = pend_q;
    need80_d       = need80_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (state_q == StIdle) chain_d = SHA256_H0;
        if (accept) begin
          block_d[word_lsb(wr_idx) +: WORD_W] = in_data;
          widx_d = wr_idx + 4'd1;
          len_d  = ((state_q == StIdle) ? '0 : len_q) + word_bits;
          if (in_last) begin
            last_idx_d   = wr_idx;
            last_bytes_d = sat_bytes(in_bytes);
          end
          if (state_q == StIdle) begin
            final_d  = 1'b0;
            pend_d   = 1'b0;
            need80_d = 1'b0;
          end
        end
      end
      StPad: begin
        cnt_d = '0;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
          if (pend_q) begin
            block_d[k*WORD_W +: WORD_W] = (k == 0 && need80_q) ? 32'h8000_0000 : 32'h0;
          end else if (k == int'(last_idx_q)) begin
            block_d[k*WORD_W +: WORD_W] = pad_out;
          end else if (k == int'(last_idx_q) + 1 && pad_ovf) begin
            block_d[k*WORD_W +: WORD_W] = 32'h8000_0000;
          end else if (k > int'(last_idx_q)) begin
            block_d[k*WORD_W +: WORD_W] = 32'h0;
          end
        end
        if (pend_q || pad_fits) begin
          block_d[14*WORD_W +: WORD_W] = len64[63:32];
          block_d[15*WORD_W +: WORD_W] = len64[31:0];
          final_d  = 1'b1;
          pend_d   = 1'b0;
          need80_d = 1'b0;
        end else begin
          // Marker still owed only when a full word ended exactly at W15.
          final_d  = 1'b0;
          pend_d   = 1'b1;
          need80_d = pad_ovf && (last_idx_q == 4'd15);
        end
      end
      StRun: cnt_d = cnt_q + 6'd1;
      StCapture: begin
        chain_d = tx_hash;
        widx_d  = '0;
        if (final_q) begin
          digest_d       = tx_hash;
          digest_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      block_q        <= '0;
      chain_q        <= SHA256_H0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      cnt_q          <= '0;
      widx_q         <= '0;
      last_idx_q     <= '0;
      last_bytes_q   <= '0;
      len_q          <= '0;
      final_q        <= 1'b0;
      pend_q         <= 1'b0;
      need80_q       <= 1'b0;
    end else begin
      block_q        <= block_d;
      chain_q        <= chain_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      cnt_q          <= cnt_d;
      widx_q         <= widx_d;
      last_idx_q     <= last_idx_d;
      last_bytes_q   <= last_bytes_d;
      len_q          <= len_d;
      final_q        <= final_d;
      pend_q         <= pend_d;
      need80_q       <= need80_d;
    end
  end

  assign rx_input     = block_q;
  assign rx_state     = chain_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;

endmodule
